sample_window_shift: RTL and testbench

- Upstream stage of the FIR datapath: accepts a serial stream of raw sensor samples over a valid/ready handshake.
- Holds the most recent NUM_REGS samples in a tap shift register and presents them in parallel to the multiply-accumulate stage.
- Flags each new full window with a valid/ready output handshake, so the downstream result capture sees exactly one window per accepted sample once primed.

---
 rtl/sample_window_shift_pkg.sv | 15 +
 rtl/sample_window_shift_if.sv | 28 ++
 rtl/constants.svh | 14 +
 rtl/sample_window_shift_tap_shift_reg.sv | 27 ++
 rtl/sample_window_shift.sv | 71 +++++++
 tb/tb_sample_window_shift.sv | 154 +++++++++++++++
 6 files changed

// File: rtl/sample_window_shift_pkg.sv
// Shared types and constants for the sample window shifter.
package sample_window_shift_pkg;
    `include "constants.svh"

    localparam int DEF_DATA_WIDTH = `DATA_WIDTH;
    localparam int DEF_NUM_REGS   = `NUM_REGS;
    localparam int FILL_W         = $clog2(`NUM_REGS + 1);

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        PRIMED,
        PENDING
    } win_state_t;
endpackage

// File: rtl/sample_window_shift_if.sv
// Sample intake and parallel window handshake bundle.
interface sample_window_shift_if
    import sample_window_shift_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS
);
    localparam int CNT_W = $clog2(NUM_REGS + 1);

    logic                  flush;
    logic [DATA_WIDTH-1:0] sampleIn;
    logic                  sampleValid;
    logic                  sampleReady;
    logic [DATA_WIDTH-1:0] pDataOut [0:NUM_REGS-1];
    logic                  windowValid;
    logic                  windowReady;
    logic [CNT_W-1:0]      fillCount;

    modport master (
        output flush, sampleIn, sampleValid, windowReady,
        input  sampleReady, pDataOut, windowValid, fillCount
    );

    modport slave (
        input  flush, sampleIn, sampleValid, windowReady,
        output sampleReady, pDataOut, windowValid, fillCount
    );
endinterface

// File: rtl/constants.svh
// Shared build-time constants for the FIR datapath.
// Override on the command line with +define+DATA_WIDTH=... / +define+NUM_REGS=...
`ifndef CONSTANTS_SVH
`define CONSTANTS_SVH

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

`ifndef NUM_REGS
`define NUM_REGS 8
`endif

`endif

// File: rtl/sample_window_shift_tap_shift_reg.sv
// Tap shift register: tap[0] takes the new sample, older taps move up by one.
module tap_shift_reg
    import sample_window_shift_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] taps [0:NUM_REGS-1]
);

    // NOTE: this array is reset on purpose; unfilled taps must read 0 downstream.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < NUM_REGS; i++) taps[i] <= '0;
        end else if (shift_en) begin
            // NOTE: non-blocking lets every tap read its neighbour's pre-edge value.
            taps[0] <= din;
            for (int i = 1; i < NUM_REGS; i++) taps[i] <= taps[i-1];
        end
    end

endmodule

// File: rtl/sample_window_shift.sv
// Sample intake, fill tracking and window handshake around the tap shift register.
module sample_window_shift
    import sample_window_shift_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS
) (
    input  logic                  clk,
    input  logic                  rst,
    sample_window_shift_if.slave  bus
);

    localparam int CNT_W = $clog2(NUM_REGS + 1);

    win_state_t       state_q, state_d;
    logic [CNT_W-1:0] fill_q;
    logic             accept;
    logic             shift_en;

    assign accept   = bus.sampleValid && bus.sampleReady;
    // Flush drops a simultaneous sample even though the producer sees it taken.
    assign shift_en = accept && !bus.flush;

    tap_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_taps (
        .clk      (clk),
        .rst      (rst),
        .clear    (bus.flush),
        .shift_en (shift_en),
        .din      (bus.sampleIn),
        .taps     (bus.pDataOut)
    );

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            fill_q <= '0;
        end else if (accept && (fill_q != CNT_W'(NUM_REGS))) begin
            fill_q <= fill_q + 1'b1;
        end
    end

    // NOTE: state_d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   if (accept) state_d = FILL;
            FILL:    if (accept) state_d = (fill_q == CNT_W'(NUM_REGS - 1)) ? PENDING : FILL;
            PRIMED:  if (accept) state_d = PENDING;
            PENDING: if (bus.windowReady && !accept) state_d = PRIMED;
            default: state_d = EMPTY;
        endcase
    end

    // windowValid is a pure decode of the state register, so it is glitch-free and registered.
    always_comb begin
        bus.windowValid = (state_q == PENDING);
        bus.sampleReady = (state_q != PENDING) || bus.windowReady;
        bus.fillCount   = fill_q;
    end

endmodule

// File: tb/tb_sample_window_shift.sv
// Randomised and directed bench for sample_window_shift against a queue-based window model.
module tb_sample_window_shift;
    import sample_window_shift_pkg::*;

    localparam int DW = 16;
    localparam int NR = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sample_window_shift_if #(.DATA_WIDTH(DW), .NUM_REGS(NR)) bus ();

    sample_window_shift #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model: newest-first list of accepted samples plus a pending-window flag.
    logic [DW-1:0]     hist [$];
    bit                m_pend;
    logic [FILL_W-1:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] m_tap(input int i);
        return (i < hist.size()) ? hist[i] : '0;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".wvalid"}, 32'(bus.windowValid), 32'(m_pend));
        check({tag, ".fill"}, 32'(bus.fillCount), 32'(m_cnt));
        for (int i = 0; i < NR; i++)
            check($sformatf("%s.tap%0d", tag, i), 32'(bus.pDataOut[i]), 32'(m_tap(i)));
    endtask

    // One clock: check ready against the current inputs, advance the model, check outputs.
    task automatic tick(input string tag);
        bit m_ready, acc;
        #1;
        m_ready = !m_pend || bus.windowReady;
        check({tag, ".ready"}, 32'(bus.sampleReady), 32'(m_ready));
        acc = bus.sampleValid && m_ready;
        if (rst || bus.flush) begin
            hist.delete();
            m_pend = 1'b0;
        end else if (acc) begin
            hist.push_front(bus.sampleIn);
            if (hist.size() > NR) void'(hist.pop_back());
            m_pend = (hist.size() == NR);
        end else if (bus.windowReady && m_pend) begin
            m_pend = 1'b0;
        end
        m_cnt = FILL_W'(hist.size());
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit wr, input bit fl);
        bus.sampleValid = v;
        bus.sampleIn    = d;
        bus.windowReady = wr;
        bus.flush       = fl;
    endtask

    initial begin
        m_pend = 1'b0;
        m_cnt  = '0;
        drive(1'b0, '0, 1'b1, 1'b0);
        rst = 1'b1;
        tick("reset");
        rst = 1'b0;
        tick("post_reset");

        // Fill with 1..8 back to back, then stream 9 and 10.
        for (int s = 1; s <= 10; s++) begin
            drive(1'b1, DW'(s), 1'b1, 1'b0);
            tick($sformatf("fill%0d", s));
            if (s == 8) check("fill_tap7_const", 32'(bus.pDataOut[7]), 32'd1);
        end
        check("stream_tap0_const", 32'(bus.pDataOut[0]), 32'd10);
        check("stream_tap7_const", 32'(bus.pDataOut[7]), 32'd3);

        // Backpressure: window pending, consumer stalls, producer waits with 0x55.
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 16'h0055, 1'b0, 1'b0);
            tick($sformatf("bp%0d", c));
        end
        drive(1'b1, 16'h0055, 1'b1, 1'b0);
        tick("bp_release");
        check("bp_tap0_const", 32'(bus.pDataOut[0]), 32'h55);

        // Flush with a simultaneous accept after 5 samples.
        drive(1'b0, '0, 1'b1, 1'b1);
        tick("pre_flush");
        for (int s = 0; s < 5; s++) begin
            drive(1'b1, DW'(16'h100 + s), 1'b1, 1'b0);
            tick($sformatf("part%0d", s));
        end
        drive(1'b1, 16'h00AA, 1'b1, 1'b1);
        tick("flush_acc");
        check("flush_fill_const", 32'(bus.fillCount), 32'd0);

        // Reset while a window is stalled.
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int s = 0; s < NR; s++) begin
            drive(1'b1, DW'($urandom), 1'b1, 1'b0);
            tick($sformatf("refill%0d", s));
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        tick("stall");
        rst = 1'b1;
        tick("mid_reset");
        rst = 1'b0;
        tick("after_reset");

        // 20 samples with 0-3 idle cycles between them, random consumer.
        for (int s = 0; s < 20; s++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                drive(1'b0, DW'($urandom), 1'($urandom), 1'b0);
                tick("gap");
            end
            drive(1'b1, DW'($urandom), 1'b1, 1'b0);
            tick($sformatf("sat%0d", s));
        end
        check("sat_fill_const", 32'(bus.fillCount), 32'(NR));

        // Free-running random traffic including rare flushes and resets.
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 2) != 0),
                  $urandom_range(0, 40) == 0);
            rst = ($urandom_range(0, 80) == 0);
            tick("rand");
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
